// File: rtl/mux16bit_821_if.sv
// Bus bundle for the registered 8-to-1 read-port selector:
// eight 16-bit data words, three discrete select bits and the registered result.
interface mux16bit_821_if;
    logic [15:0] A0, A1, A2, A3, A4, A5, A6, A7;
    logic        s0, s1, s2;
    logic [15:0] Y;

    modport master (output A0, A1, A2, A3, A4, A5, A6, A7, s0, s1, s2, input Y);
    modport slave  (input  A0, A1, A2, A3, A4, A5, A6, A7, s0, s1, s2, output Y);
endinterface

// File: rtl/mux16bit_821.sv
// Registered 8-to-1 mux of 16-bit words for the register-file read port.
// Y reloads every clock with A[{s2,s1,s0}]; async active-low reset clears Y.
module mux16bit_821 (
    input  logic          clk,
    input  logic          rst_n,
    mux16bit_821_if.slave bus
);
    logic [7:0][15:0] a;
    logic [2:0]       sel;
    logic [15:0]      nxt;
    logic [15:0]      y_q;

    // Pack so that a[i] is Ai; s2 is the select MSB.
    assign a   = {bus.A7, bus.A6, bus.A5, bus.A4, bus.A3, bus.A2, bus.A1, bus.A0};
    assign sel = {bus.s2, bus.s1, bus.s0};

    always_comb begin
        nxt = a[sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) y_q <= 16'h0000;
        else        y_q <= nxt;
    end

    assign bus.Y = y_q;
endmodule

// File: tb/tb_mux16bit_821.sv
// Self-checking bench for mux16bit_821: expected words are queued when
// stimulus is applied and popped when the registered output is sampled.
module tb_mux16bit_821;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    mux16bit_821_if bus();

    mux16bit_821 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [2:0] v);
        {bus.s2, bus.s1, bus.s0} = v;
    endtask

    task automatic set_all(input logic [15:0] v);
        bus.A0 = v; bus.A1 = v; bus.A2 = v; bus.A3 = v;
        bus.A4 = v; bus.A5 = v; bus.A6 = v; bus.A7 = v;
    endtask

    task automatic test_reset();
        set_all(16'hFFFF);
        set_sel(3'd7);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.Y !== 16'h0000) begin
            fails++;
            $display("FAIL reset_async: got %h want 0000", bus.Y);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (bus.Y !== 16'h0000) begin
                fails++;
                $display("FAIL reset_hold[%0d]: got %h want 0000", i, bus.Y);
            end
        end
        rst_n = 1'b1;
        exp_q.push_back(16'hFFFF);
        step();
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL reset_release: scoreboard empty, got %h", bus.Y);
        end else begin
            exp_v = exp_q.pop_front();
            if (bus.Y !== exp_v) begin
                fails++;
                $display("FAIL reset_release: got %h want %h", bus.Y, exp_v);
            end
        end
    endtask

    task automatic test_sweep();
        bus.A0 = 16'h0000; bus.A1 = 16'h0001; bus.A2 = 16'h0010; bus.A3 = 16'h0011;
        bus.A4 = 16'h0100; bus.A5 = 16'h0101; bus.A6 = 16'h0110; bus.A7 = 16'h0111;
        for (int s = 0; s < 8; s++) begin
            set_sel(3'(s));
            exp_q.push_back({3'b000, s[2], 3'b000, s[1], 3'b000, s[0], 4'h0} >> 4);
            step();
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sweep[%0d]: scoreboard empty, got %h", s, bus.Y);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.Y !== exp_v) begin
                    fails++;
                    $display("FAIL sweep[%0d]: got %h want %h", s, bus.Y, exp_v);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [2:0]  sels [3] = '{3'd7, 3'd0, 3'd4};
        logic [15:0] exps [3] = '{16'h0111, 16'h0000, 16'h0100};
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                bus.s2 = 1'b1;
                bus.s1 = 1'b0;
                bus.s0 = 1'b0;
            end else begin
                set_sel(sels[i]);
            end
            exp_q.push_back(exps[i]);
            step();
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL wrap[%0d]: scoreboard empty, got %h", i, bus.Y);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.Y !== exp_v) begin
                    fails++;
                    $display("FAIL wrap[%0d]: got %h want %h", i, bus.Y, exp_v);
                end
            end
        end
    endtask

    task automatic test_data_tracking();
        set_sel(3'd3);
        bus.A3 = 16'h1234;
        exp_q.push_back(16'h1234);
        step();
        #3;
        bus.A3 = 16'hABCD;
        #1;
        tests++;
        if (bus.Y !== 16'h1234) begin
            fails++;
            $display("FAIL track_midcycle: got %h want 1234", bus.Y);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) exp_q.push_back(16'hABCD);
            if (i == 2) begin
                bus.A5 = 16'h5A5A;
                exp_q.push_back(16'hABCD);
            end
            if (i > 0) step();
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL track[%0d]: scoreboard empty, got %h", i, bus.Y);
            end else begin
                exp_v = exp_q.pop_front();
                if (i == 0) begin
                    // value queued before the mid-cycle change: already checked live
                    if (exp_v !== 16'h1234 || bus.Y !== exp_v) begin
                        fails++;
                        $display("FAIL track[%0d]: got %h want %h", i, bus.Y, exp_v);
                    end
                end else if (bus.Y !== exp_v) begin
                    fails++;
                    $display("FAIL track[%0d]: got %h want %h", i, bus.Y, exp_v);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bus.A5 = 16'h0101;
        set_sel(3'd5);
        exp_q.push_back(16'h0101);
        step();
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL arst_pre: scoreboard empty, got %h", bus.Y);
        end else begin
            exp_v = exp_q.pop_front();
            if (bus.Y !== exp_v) begin
                fails++;
                $display("FAIL arst_pre: got %h want %h", bus.Y, exp_v);
            end
        end
        set_sel(3'd2);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.Y !== 16'h0000) begin
            fails++;
            $display("FAIL arst_midcycle: got %h want 0000", bus.Y);
        end
        step();
        tests++;
        if (bus.Y !== 16'h0000) begin
            fails++;
            $display("FAIL arst_hold: got %h want 0000", bus.Y);
        end
        rst_n = 1'b1;
        exp_q.push_back(16'h0010);
        step();
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL arst_release: scoreboard empty, got %h", bus.Y);
        end else begin
            exp_v = exp_q.pop_front();
            if (bus.Y !== exp_v) begin
                fails++;
                $display("FAIL arst_release: got %h want %h", bus.Y, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.A6 = 16'h8001;
        bus.A1 = 16'h7FFE;
        for (int i = 0; i < 8; i++) begin
            set_sel((i % 2 == 0) ? 3'd6 : 3'd1);
            exp_q.push_back((i % 2 == 0) ? 16'h8001 : 16'h7FFE);
            step();
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL alt[%0d]: scoreboard empty, got %h", i, bus.Y);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.Y !== exp_v) begin
                    fails++;
                    $display("FAIL alt[%0d]: got %h want %h", i, bus.Y, exp_v);
                end
            end
        end
    endtask

    initial begin
        set_all(16'h0000);
        set_sel(3'd0);
        test_reset();
        test_sweep();
        test_wrap();
        test_data_tracking();
        test_async_reset();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: sim time %0t exceeded budget", $time);
        $fatal(1);
    end
endmodule

// File: doc/mux16bit_821.md
# mux16bit_821

Registered 8-to-1 multiplexer for 16-bit words, used as a read-port selector in the register-file datapath. A 3-bit select, presented as three discrete bits `s2:s1:s0`, chooses one of eight 16-bit inputs `A0`–`A7`. The chosen word is captured into an output register on each rising clock edge. An asynchronous active-low reset clears the output register.

## Interface
Parameters:
- None. The data width is fixed at 16 bits and the input count is fixed at 8.

Ports:
- `clk`  input  1  — single system clock; all state updates on its rising edge.
- `rst_n`  input  1  — reset, asynchronous, active-low; clears `Y` immediately when asserted.
- `A0`  input  16  — data input selected when `{s2,s1,s0}` = 3'b000.
- `A1`  input  16  — selected when select = 3'b001.
- `A2`  input  16  — selected when select = 3'b010.
- `A3`  input  16  — selected when select = 3'b011.
- `A4`  input  16  — selected when select = 3'b100.
- `A5`  input  16  — selected when select = 3'b101.
- `A6`  input  16  — selected when select = 3'b110.
- `A7`  input  16  — selected when select = 3'b111.
- `s0`  input  1  — select bit 0 (LSB).
- `s1`  input  1  — select bit 1.
- `s2`  input  1  — select bit 2 (MSB).
- `Y`  output  16  — registered selected word.

## Operation
- Select index: `sel = {s2, s1, s0}`, unsigned, range 0–7.
- Next-state value: `A[sel]`, computed combinationally and fully decoded.
  - All 8 codes are valid; there is no default or illegal code.
  - The next-state logic contains no latches.
- On each rising edge of `clk` with `rst_n` high, `Y` <= `A[sel]`.
- No enable input; `Y` reloads every cycle.
- Bit-for-bit pass-through: no width conversion, no sign handling, no inversion.
- Inputs that do not change between edges produce a stable `Y`.
- Reset behaviour:
  - `rst_n` low forces `Y` = 16'h0000 immediately, without waiting for a clock edge.
  - `Y` holds at 16'h0000 for as long as `rst_n` stays low, regardless of the `A*` and `s*` inputs.
- Reset release:
  - The first rising edge after `rst_n` goes high loads `A[sel]`.
  - Release is expected to be synchronized upstream; the block adds no release synchronizer.
- X/Z on select or data inputs: no special handling is required. Behaviour follows the synthesized mux.

## Timing
- Latency: 1 clock. Inputs sampled at edge N appear on `Y` just after edge N.
  - `Y` stays stable until edge N+1.
- Select and data changes between edges have no effect on `Y` until the next edge, so there are no output glitches.
- Simultaneous change of select and data before an edge: `Y` takes the new data on the new select.
- Back-to-back select changes on consecutive cycles: each cycle's selection is reflected one cycle later; none is skipped.
- Select wrap: moving from 3'b111 to 3'b000 is an ordinary change; the next edge loads `A0`.
- Reset asserted mid-stream:
  - `Y` goes to 0 asynchronously.
  - The pending selection is discarded.
- Reset value of every output: `Y` = 16'h0000.
- Combinational path: `A*`/`s*` to the `Y` register D input only. There is no combinational input-to-`Y` path.

## Test plan
- Reset check:
  - Drive `rst_n`=0 with all `A*`=16'hFFFF and sel=7 → `Y`=16'h0000 without any clock edge; `Y` holds 0 across 3 clocks.
  - Release reset → `Y`=16'hFFFF after the first edge.
- Select sweep:
  - Load `A0`..`A7` = 16'h0000, 0001, 0010, 0011, 0100, 0101, 0110, 0111.
  - Step sel 0→7, one value per cycle.
  - Expected: `Y` one cycle later = 0000, 0001, 0010, 0011, 0100, 0101, 0110, 0111.
- Wrap and bit order:
  - Continue the sweep from sel=7 to sel=0 → `Y`=16'h0111, then 16'h0000.
  - Set only `s2`=1 → `Y`=16'h0100 (confirms `s2` is the MSB).
- Data tracking:
  - Hold sel=3 and change `A3` 16'h1234→16'hABCD mid-cycle → `Y` updates to 16'hABCD only at the next edge.
  - Change `A5` → `Y` unaffected.
- Async reset mid-operation:
  - With `Y`=16'h0101, pull `rst_n` low between edges → `Y`=16'h0000 before the next edge.
  - Release → `Y` follows the current selection after one edge.
- Bit independence:
  - Load `A6`=16'h8001 and `A1`=16'h7FFE.
  - Alternate sel 6/1 every cycle → `Y` alternates 8001/7FFE with no bit errors.
